uart_fifo_io: RTL and testbench
===============================

Name: uart_fifo_io

Overview:
Memory-mapped full-duplex UART for the HACK I/O space. It is the buffered, parametrised successor to the single-byte UART TX/RX devices. It occupies two consecutive I/O words (TX, RX) behind the memory decoder, and holds parametrised-depth FIFOs on both directions. The CPU can burst-write and lag on reads without losing bytes, and sticky overrun and framing flags report errors.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
BAUD, 115200, line rate; bit period DIV = CLK_HZ/BAUD (integer, truncated, must be >= 4)
DEPTH, 16, entries per FIFO; power of two, 2..256
AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk      in   1   system clock (25 MHz domain)
reset    in   1   asynchronous, active-high reset
load     in   1   write strobe from memory decoder (writeM qualified by address)
addr     in   1   0 = TX word, 1 = RX word
in       in   16  CPU write data (outM)
out      out  16  read data for the selected word, combinational from state
RX       in   1   serial input, idle high, asynchronous to clk
TX       out  1   serial output, idle high
rx_avail out  1   high while RX FIFO is non-empty (interrupt or poll hint)

Behaviour:
- Reset (async): both FIFOs empty with pointers 0; TX=1; TX FSM in IDLE; RX FSM in IDLE; overrun=0; ferr=0; rx_avail=0; RX synchroniser flops set to 1.
- Frame format: 8N1, LSB first. 1 start bit (0), 8 data bits, 1 stop bit (1). Each bit lasts DIV clocks.
- TX word read (addr=0): out = {tx_full, 15'(tx_count)}. Value 0 means idle and empty.
- TX word write (addr=0, load=1): pushes in[7:0] if not full. A push while full is dropped silently; tx_full stays set.
- RX word read (addr=1): out = {rx_empty, overrun, ferr, 5'b0, head_byte}. When empty, head_byte reads 8'h00.
- RX word write (addr=1, load=1): pops the head if non-empty; a pop while empty is a no-op. in[14]=1 clears overrun. in[13]=1 clears ferr.
- Flags and counts update on the clock edge after load. out reflects the new state in the following cycle.
- TX FSM: IDLE -> START -> DATA (8 bits) -> STOP -> IDLE.
  - In IDLE with FIFO non-empty, pop the head into the shift register. TX drives 0 on the next cycle, which is the start of the start bit.
  - Each state lasts DIV clocks, counted by a divider counter that reloads at each bit.
  - After STOP, if the FIFO is non-empty, go directly to START with the next byte. No idle gap beyond the pop cycle (back-to-back frames: 10*DIV+1 clocks each).
- RX path:
  - RX passes through a 2-flop synchroniser.
  - IDLE: a falling edge on the synchronised RX enters START and counts DIV/2.
  - START: at mid-bit, if RX=1 it is a glitch; return to IDLE with no flag. Otherwise enter DATA.
  - DATA: sample 8 bits, one every DIV clocks, at mid-bit.
  - STOP: sample at mid-bit.
    - Stop=1 with FIFO not full: push the byte.
    - Stop=1 with FIFO full: discard the byte and set overrun.
    - Stop=0: discard the byte and set ferr.
  - Return to IDLE immediately after the stop sample, so the next start edge is detectable within the second half of the stop bit.
- Simultaneous events:
  - CPU push and TX pop in the same cycle on a full FIFO: pop first, so the push is accepted and the count is unchanged.
  - RX push and CPU pop in the same cycle on a full FIFO: the push is accepted with no overrun.
  - Simultaneous push and pop on an empty FIFO: the push is accepted and the pop is ignored.
- Counts: tx_count is in the range 0..DEPTH; it is stored with AW+1 bits and zero-extended to 15. Pointers wrap modulo DEPTH.
- Reset mid-frame: TX returns to 1 immediately. A partial RX frame is discarded.

Test Plan:
1. Reset, with CLK_HZ=16, BAUD=1 (DIV=16): read TX -> 0x0000, read RX -> 0x8000, TX=1. Write 0x0055 to TX -> TX low for 16 clocks, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then high 16 clocks. Read TX -> 0x0000 afterwards.
2. Write 17 bytes 0x01..0x11 in consecutive cycles (DEPTH=16). First pops into the shifter, so 16 queued. Read TX -> 0x8010. 18th write is dropped. Wire output carries 0x01..0x11 back-to-back, 161 clocks per frame.
3. Drive RX frame 0xA3 at DIV=16 -> rx_avail=1, read RX -> 0x00A3. Write RX with 0 -> read RX -> 0x8000.
4. Send 17 frames without popping -> read RX -> 0x4001 (head 0x01, overrun). Write RX with 0x4000 -> overrun clear, head 0x02.
5. Frame with stop bit 0 -> nothing pushed, read RX -> 0xA000. Write 0x2000 -> 0x8000. A 3-clock low glitch on RX -> no push, no flag.
6. Assert reset midway through a TX frame and an RX frame -> TX=1 within the same cycle. After release: TX read 0x0000, RX read 0x8000, rx_avail=0.

Source files
------------

// File: rtl/uart_fifo_io_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_fifo_io_if                                        |
// | Description : CPU-side bus of the buffered UART: write strobe, word  |
// |               select, write data, read data and RX-available hint.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface uart_fifo_io_if;
    logic        load;
    logic        addr;
    logic [15:0] in;
    logic [15:0] out;
    logic        rx_avail;

    modport master (output load, addr, in, input out, rx_avail);
    modport slave  (input load, addr, in, output out, rx_avail);
endinterface
`default_nettype wire

// File: rtl/uart_fifo_io.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_fifo_io                                           |
// | Description : Memory-mapped full-duplex 8N1 UART with DEPTH-entry    |
// |               TX and RX FIFOs, sticky overrun and framing flags.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_fifo_io #(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  wire            clk,
    input  wire            reset,
    uart_fifo_io_if.slave  bus,
    input  wire            RX,
    output logic           TX
);
    localparam int AW = $clog2(DEPTH);
    localparam int c_DIV = CLK_HZ / BAUD;
    localparam int c_DW  = $clog2(c_DIV);
    localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(c_DIV - 1);
    localparam logic [c_DW-1:0] c_HALF_LAST = c_DW'(c_DIV / 2 - 1);
    localparam logic [AW:0]     c_FULL      = (AW + 1)'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // ------------------------------------------------------------ TX side
    logic [7:0]      r_tx_mem [DEPTH];
    logic [AW-1:0]   r_tx_wp, r_tx_rp;
    logic [AW:0]     r_tx_count;
    logic [7:0]      r_tx_shift;
    logic [1:0]      r_tx_state, w_tx_state_nxt;
    logic [c_DW-1:0] r_tx_div, w_tx_div_nxt;
    logic [2:0]      r_tx_bit, w_tx_bit_nxt, w_tx_bit_inc;
    logic            r_tx_line, w_tx_line_nxt;
    logic            w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;

    assign w_tx_full    = (r_tx_count == c_FULL);
    assign w_tx_empty   = (r_tx_count == '0);
    assign w_tx_bit_inc = r_tx_bit + 3'd1;
    // A TX pop in the same cycle frees a slot, so a push on a full FIFO still lands
    assign w_tx_push    = bus.load & ~bus.addr & (~w_tx_full | w_tx_pop);
    assign TX           = r_tx_line;

    // TX FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.in[7:0];
    end

    // TX FIFO pointers, occupancy and shifter load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_count <= '0;
            r_tx_shift <= 8'h00;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop) begin
                r_tx_rp    <= r_tx_rp + 1'b1;
                r_tx_shift <= r_tx_mem[r_tx_rp];
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // TX state register; the line idles high and snaps high on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state <= c_ST_IDLE;
            r_tx_div   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_div   <= w_tx_div_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_line  <= w_tx_line_nxt;
        end
    end

    // TX next state: the IDLE cycle doubles as the pop cycle between frames
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_div_nxt   = r_tx_div;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_line_nxt  = r_tx_line;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            c_ST_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop       = 1'b1;
                    w_tx_state_nxt = c_ST_START;
                    w_tx_div_nxt   = c_DIV_LAST;
                    w_tx_line_nxt  = 1'b0;
                end
            end
            c_ST_START: begin
                if (r_tx_div == '0) begin
                    w_tx_state_nxt = c_ST_DATA;
                    w_tx_div_nxt   = c_DIV_LAST;
                    w_tx_bit_nxt   = 3'd0;
                    w_tx_line_nxt  = r_tx_shift[0];
                end else begin
                    w_tx_div_nxt = r_tx_div - 1'b1;
                end
            end
            c_ST_DATA: begin
                if (r_tx_div == '0) begin
                    w_tx_div_nxt = c_DIV_LAST;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = c_ST_STOP;
                        w_tx_line_nxt  = 1'b1;
                    end else begin
                        w_tx_bit_nxt  = w_tx_bit_inc;
                        w_tx_line_nxt = r_tx_shift[w_tx_bit_inc];
                    end
                end else begin
                    w_tx_div_nxt = r_tx_div - 1'b1;
                end
            end
            c_ST_STOP: begin
                if (r_tx_div == '0) w_tx_state_nxt = c_ST_IDLE;
                else                w_tx_div_nxt   = r_tx_div - 1'b1;
            end
            default: w_tx_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ RX side
    logic [7:0]      r_rx_mem [DEPTH];
    logic [AW-1:0]   r_rx_wp, r_rx_rp;
    logic [AW:0]     r_rx_count;
    logic            r_rx_s1, r_rx_s2, r_rx_prev;
    logic [7:0]      r_rx_data, w_rx_data_nxt;
    logic [1:0]      r_rx_state, w_rx_state_nxt;
    logic [c_DW-1:0] r_rx_div, w_rx_div_nxt;
    logic [2:0]      r_rx_bit, w_rx_bit_nxt;
    logic            w_rx_done, w_rx_good;
    logic            w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
    logic            r_overrun, r_ferr;
    logic [7:0]      w_rx_head;
    logic            w_unused_in;

    assign w_rx_full   = (r_rx_count == c_FULL);
    assign w_rx_empty  = (r_rx_count == '0);
    assign w_rx_pop    = bus.load & bus.addr & ~w_rx_empty;
    assign w_rx_good   = w_rx_done & r_rx_s2;
    // A CPU pop in the same cycle makes room, so that byte is not an overrun
    assign w_rx_push   = w_rx_good & (~w_rx_full | w_rx_pop);
    assign w_rx_head   = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp];
    assign bus.rx_avail = ~w_rx_empty;
    assign w_unused_in = &{1'b0, bus.in[15], bus.in[12:8]};

    // Two-flop synchroniser plus edge-detect history, idle high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX FIFO storage write port
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_data;
    end

    // RX FIFO pointers, occupancy and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_count <= '0;
            r_overrun  <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
            // A new error in the same cycle as a clear wins, so it is never lost
            if (w_rx_good && w_rx_full && !w_rx_pop)  r_overrun <= 1'b1;
            else if (bus.load && bus.addr && bus.in[14]) r_overrun <= 1'b0;
            if (w_rx_done && !r_rx_s2)                r_ferr <= 1'b1;
            else if (bus.load && bus.addr && bus.in[13]) r_ferr <= 1'b0;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state <= c_ST_IDLE;
            r_rx_div   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_data  <= 8'h00;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_div   <= w_rx_div_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_data  <= w_rx_data_nxt;
        end
    end

    // RX next state: samples at mid-bit, back to IDLE right after the stop sample
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_div_nxt   = r_rx_div;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_data_nxt  = r_rx_data;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            c_ST_IDLE: begin
                if (r_rx_prev && !r_rx_s2) begin
                    w_rx_state_nxt = c_ST_START;
                    w_rx_div_nxt   = c_HALF_LAST;
                end
            end
            c_ST_START: begin
                if (r_rx_div == '0) begin
                    if (r_rx_s2) begin
                        w_rx_state_nxt = c_ST_IDLE;
                    end else begin
                        w_rx_state_nxt = c_ST_DATA;
                        w_rx_div_nxt   = c_DIV_LAST;
                        w_rx_bit_nxt   = 3'd0;
                    end
                end else begin
                    w_rx_div_nxt = r_rx_div - 1'b1;
                end
            end
            c_ST_DATA: begin
                if (r_rx_div == '0) begin
                    w_rx_data_nxt[r_rx_bit] = r_rx_s2;
                    w_rx_div_nxt            = c_DIV_LAST;
                    if (r_rx_bit == 3'd7) w_rx_state_nxt = c_ST_STOP;
                    else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
                end else begin
                    w_rx_div_nxt = r_rx_div - 1'b1;
                end
            end
            c_ST_STOP: begin
                if (r_rx_div == '0) begin
                    w_rx_done      = 1'b1;
                    w_rx_state_nxt = c_ST_IDLE;
                end else begin
                    w_rx_div_nxt = r_rx_div - 1'b1;
                end
            end
            default: w_rx_state_nxt = c_ST_IDLE;
        endcase
    end

    // Read mux for the selected word
    always_comb begin
        if (bus.addr) bus.out = {w_rx_empty, r_overrun, r_ferr, 5'b0, w_rx_head};
        else          bus.out = {w_tx_full, 15'(r_tx_count)};
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_io.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_fifo_io                                        |
// | Description : Directed bench for uart_fifo_io at DIV=16, DEPTH=16.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_fifo_io;
    localparam int CLK_HZ = 16;
    localparam int BAUD   = 1;
    localparam int DEPTH  = 16;
    localparam int DIV    = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic RX    = 1'b1;
    logic TX;

    uart_fifo_io_if bus();

    uart_fifo_io #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .RX    (RX),
        .TX    (TX)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          do_wr;
        bit          wr_addr;
        logic [15:0] wr_data;
        bit          rd_addr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic a, input logic [15:0] d);
        @(negedge clk);
        bus.load = 1'b1;
        bus.addr = a;
        bus.in   = d;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        bus.in   = 16'h0000;
    endtask

    task automatic bus_read(input logic a, output logic [15:0] d);
        bus.addr = a;
        #1;
        d = bus.out;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [15:0] d;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].wr_addr, vecs[i].wr_data);
            bus_read(vecs[i].rd_addr, d);
            check($sformatf("vec%0d", i), d, vecs[i].exp);
        end
    endtask

    // Waits for a start bit, then checks every clock of the 10-bit frame
    task automatic tx_frame(input logic [7:0] b, input bit chk_gap);
        int waits;
        int errs;
        logic [9:0] f;
        waits = 0;
        errs  = 0;
        f     = {1'b1, b, 1'b0};
        do begin
            @(negedge clk);
            waits++;
        end while (TX !== 1'b0 && waits < 400);
        if (TX !== 1'b0) begin
            check($sformatf("tx_start_%02h", b), {15'b0, TX}, 16'h0000);
            return;
        end
        if (chk_gap) check($sformatf("tx_gap_%02h", b), 16'(waits), 16'd2);
        for (int k = 0; k < 10 * DIV; k++) begin
            if (k > 0) @(negedge clk);
            if (TX !== f[k / DIV]) errs++;
        end
        check($sformatf("tx_frame_%02h", b), 16'(errs), 16'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            RX = f[k];
            repeat (DIV) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic tx_stays_high(input string name, input int cycles);
        int errs;
        errs = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (TX !== 1'b1) errs++;
        end
        check(name, 16'(errs), 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] d;

        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h4001};
        vecs[3]  = '{1'b1, 1'b1, 16'h4000, 1'b1, 16'h0002};
        for (int i = 4; i <= 17; i++)
            vecs[i] = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'(i - 1)};
        vecs[18] = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'h8000};
        vecs[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA000};
        vecs[20] = '{1'b1, 1'b1, 16'h2000, 1'b1, 16'h8000};
        vecs[21] = '{1'b1, 1'b1, 16'h0000, 1'b1, 16'h8000};
        vecs[22] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};

        bus.load = 1'b0;
        bus.addr = 1'b0;
        bus.in   = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and a single TX frame
        run_vecs(0, 1);
        check("tx_idle_reset", {15'b0, TX}, 16'h0001);
        check("rx_avail_reset", {15'b0, bus.rx_avail}, 16'h0000);
        bus_write(1'b0, 16'h0055);
        tx_frame(8'h55, 1'b1);
        bus_read(1'b0, d);
        check("tx_word_after_frame", d, 16'h0000);

        // TX burst: fill, overflow drop, back-to-back frames
        fork
            begin
                for (int i = 1; i <= 17; i++) bus_write(1'b0, 16'(i));
                bus_read(1'b0, d);
                check("tx_full_count", d, 16'h8010);
                bus_write(1'b0, 16'h0012);
                bus_read(1'b0, d);
                check("tx_drop_full", d, 16'h8010);
            end
            begin
                tx_frame(8'h01, 1'b0);
                for (int i = 2; i <= 17; i++) tx_frame(8'(i), 1'b1);
            end
        join
        tx_stays_high("tx_no_dropped_frame", 200);
        bus_read(1'b0, d);
        check("tx_drained", d, 16'h0000);

        // Single RX frame, then pop
        send_rx(8'hA3, 1'b1);
        check("rx_avail_set", {15'b0, bus.rx_avail}, 16'h0001);
        bus_read(1'b1, d);
        check("rx_head_a3", d, 16'h00A3);
        bus_write(1'b1, 16'h0000);
        bus_read(1'b1, d);
        check("rx_empty_after_pop", d, 16'h8000);
        check("rx_avail_clear", {15'b0, bus.rx_avail}, 16'h0000);

        // RX overrun on the 17th frame, then drain through the table
        for (int i = 1; i <= 17; i++) send_rx(8'(i), 1'b1);
        run_vecs(2, 18);

        // Framing error, clear, glitch rejection
        send_rx(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        run_vecs(19, 20);
        RX = 1'b0;
        repeat (3) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_avail", {15'b0, bus.rx_avail}, 16'h0000);
        run_vecs(21, 22);

        // Reset in the middle of a TX frame and an RX frame
        bus_write(1'b0, 16'h0000);
        repeat (50) @(negedge clk);
        RX = 1'b0;
        repeat (20) @(negedge clk);
        check("tx_busy_pre_reset", {15'b0, TX}, 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        check("tx_high_on_reset", {15'b0, TX}, 16'h0001);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tx_stays_high("tx_idle_after_reset", 200);
        bus_read(1'b0, d);
        check("tx_word_after_reset", d, 16'h0000);
        bus_read(1'b1, d);
        check("rx_word_after_reset", d, 16'h8000);
        check("rx_avail_after_reset", {15'b0, bus.rx_avail}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
